// File: rtl/div_32.sv
// Signed 32-bit restoring divider, one quotient bit per clock.
// Truncates toward zero; flags divide-by-zero and the 0x80000000 / -1 overflow.
module div_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] divisor_mag;
  logic [31:0] rem;
  logic [31:0] quo;
  logic        sign;
  logic        overflow;

  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic        divisor_zero;

  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  assign divisor_zero = (data_operandB == 32'd0);

  // rem < |B| <= 2^31 before the shift, so the difference always fits in 32 bits
  always_comb begin
    rem_shift = {rem, quo[31]};
    rem_ge    = (rem_shift >= {1'b0, divisor_mag});
    rem_next  = rem_ge ? (rem_shift[31:0] - divisor_mag) : rem_shift[31:0];
    quo_next  = {quo[30:0], rem_ge};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A start pulse wins in every state, which is also how an in-flight division is aborted
  always_comb begin
    state_next = state;
    if (ctrl_DIV) begin
      state_next = divisor_zero ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     state_next = (count == 5'd31) ? FIX : RUN;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count          <= 5'd0;
      divisor_mag    <= 32'd0;
      rem            <= 32'd0;
      quo            <= 32'd0;
      sign           <= 1'b0;
      overflow       <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      count       <= 5'd0;
      divisor_mag <= magnitude(data_operandB);
      rem         <= 32'd0;
      quo         <= magnitude(data_operandA);
      sign        <= data_operandA[31] ^ data_operandB[31];
      overflow    <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      if (divisor_zero) begin
        data_result    <= 32'd0;
        data_exception <= 1'b1;
      end
    end else if (state == RUN) begin
      rem   <= rem_next;
      quo   <= quo_next;
      count <= count + 5'd1;
    end else if (state == FIX) begin
      data_result    <= sign ? (~quo + 32'd1) : quo;
      data_exception <= overflow;
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state == RUN) || (state == FIX);

endmodule

// File: tb/tb_div_32.sv
// Directed-vector bench for div_32: table of quotient cases plus abort and
// mid-division reset sequences, all expectations hand-computed.
module tb_div_32;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        exc;
    int          latency;
  } vec_t;

  vec_t vectors[12];

  div_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Presents a start pulse across one rising edge, then scrambles the operands
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_ready(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!data_resultRDY && cycles < 60) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      cycles++;
    end
    if (busy) busy_cycles++;
  endtask

  task automatic run_vector(input vec_t v);
    int cycles, busy_cycles;
    logic [31:0] held;
    applyStimulus(v.a, v.b);
    wait_ready(cycles, busy_cycles);
    checkOutput({v.name, " latency"}, cycles, v.latency);
    checkOutput({v.name, " busy cycles"}, busy_cycles, v.latency);
    checkOutput({v.name, " result"}, data_result, v.result);
    checkOutput({v.name, " exception"}, {31'd0, data_exception}, {31'd0, v.exc});
    held = data_result;
    @(negedge clock);
    checkOutput({v.name, " rdy single pulse"}, {31'd0, data_resultRDY}, 32'd0);
    repeat (3) @(negedge clock);
    checkOutput({v.name, " result held"}, data_result, held);
  endtask

  initial begin
    int cycles, busy_cycles, rdy_seen;

    vectors[0]  = '{"100/7",       32'd100,        32'd7,          32'd14,         1'b0, 33};
    vectors[1]  = '{"-100/7",      32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, 33};
    vectors[2]  = '{"-100/-7",     32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 33};
    vectors[3]  = '{"7/-100",      32'd7,          32'hFFFF_FF9C,  32'd0,          1'b0, 33};
    vectors[4]  = '{"7/0",         32'd7,          32'd0,          32'd0,          1'b1, 0};
    vectors[5]  = '{"min/-1",      32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 33};
    vectors[6]  = '{"min/1",       32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 33};
    vectors[7]  = '{"min/min",     32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0, 33};
    vectors[8]  = '{"max/min",     32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
    vectors[9]  = '{"-7/2",        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 33};
    vectors[10] = '{"1000000/3",   32'd1000000,    32'd3,          32'd333333,     1'b0, 33};
    vectors[11] = '{"0/0",         32'd0,          32'd0,          32'd0,          1'b1, 0};

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    #12;
    checkOutput("reset result", data_result, 32'd0);
    checkOutput("reset exception", {31'd0, data_exception}, 32'd0);
    checkOutput("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vector(vectors[i]);

    // Restart at cycle 10 with 50/5; the first division must never report
    applyStimulus(32'd100, 32'd7);
    rdy_seen = 0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    applyStimulus(32'd50, 32'd5);
    wait_ready(cycles, busy_cycles);
    checkOutput("abort latency", cycles, 33);
    checkOutput("abort result", data_result, 32'd10);
    checkOutput("abort exception", {31'd0, data_exception}, 32'd0);
    if (data_resultRDY) rdy_seen++;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    checkOutput("abort rdy pulses", rdy_seen, 1);

    // Reset mid-division clears everything at once and suppresses the ready pulse
    applyStimulus(32'd100, 32'd7);
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset result", data_result, 32'd0);
    checkOutput("midreset exception", {31'd0, data_exception}, 32'd0);
    checkOutput("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    rdy_seen = 0;
    busy_cycles = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
      if (busy) busy_cycles++;
    end
    checkOutput("midreset rdy pulses", rdy_seen, 0);
    checkOutput("midreset busy after", busy_cycles, 0);

    run_vector(vectors[0]);
    run_vector(vectors[4]);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
